can_fault_counters: RTL



---
 rtl/can_fc_pkg.sv | 19 +
 rtl/can_err_counter.sv | 50 +++++
 rtl/can_fault_counters.sv | 84 ++++++++
 3 files changed

// File: rtl/can_fc_pkg.sv
// can_fc_pkg: fault-confinement state encodings, default thresholds and display saturation.
package can_fc_pkg;
  typedef enum logic [1:0] {
    FC_ACTIVE  = 2'b00,
    FC_PASSIVE = 2'b01,
    FC_BUSOFF  = 2'b10
  } fc_state_t;
  localparam int DEF_CNT_W      = 9;
  localparam int DEF_WARN_LVL   = 96;
  localparam int DEF_PASSIVE    = 128;
  localparam int DEF_BUSOFF     = 256;
  localparam int DEF_TX_INC     = 8;
  localparam int DEF_REC_RELOAD = 119;
  localparam int RX_INC8        = 8;
  localparam int RCV11_EXIT_CNT = 128;
  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/can_err_counter.sv
// can_err_counter: edge-detected saturating up/down error counter with optional reload.
module can_err_counter #(
  parameter int CNT_W      = 9,
  parameter int STEP       = 8,
  parameter int INC_LIM    = 512,
  parameter bit RELOAD_EN  = 1'b0,
  parameter int RELOAD_LVL = 128,
  parameter int RELOAD_VAL = 119
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc_step,
  input  logic             i_inc_one,
  input  logic             i_dec,
  input  logic             i_hold,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt
);
  logic             r_flag;
  logic [CNT_W-1:0] r_cnt, w_nxt, w_up_step, w_up_one, w_down;
  logic [CNT_W:0]   w_sum_step, w_sum_one;
  logic             w_any, w_act, w_inc_ok;
  always_comb begin
    w_any      = i_inc_step | i_inc_one | i_dec;
    w_act      = w_any & ~r_flag & ~i_hold;
    w_inc_ok   = int'(r_cnt) < INC_LIM;
    w_sum_step = {1'b0, r_cnt} + (CNT_W+1)'(STEP);
    w_sum_one  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    w_up_step  = w_sum_step[CNT_W] ? '1 : w_sum_step[CNT_W-1:0];
    w_up_one   = w_sum_one[CNT_W] ? '1 : w_sum_one[CNT_W-1:0];
    w_down     = (RELOAD_EN && int'(r_cnt) >= RELOAD_LVL) ? CNT_W'(RELOAD_VAL) :
                 (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_nxt      = i_clr ? '0 :
                 !w_act ? r_cnt :
                 i_inc_step ? (w_inc_ok ? w_up_step : r_cnt) :
                 i_inc_one ? w_up_one : w_down;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flag <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_flag <= w_any;
      r_cnt  <= w_nxt;
    end
  end
  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_nxt;
endmodule

// File: rtl/can_fault_counters.sv
// can_fault_counters: CAN TEC/REC fault confinement with error-active/passive/bus-off state.
// Define CAN_FC_BUSOFF_RECOVERY_EN to leave bus-off after 128 rcv11 events instead of busoff_clr.
module can_fault_counters
  import can_fc_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WARN_LVL    = DEF_WARN_LVL,
  parameter int PASSIVE_LVL = DEF_PASSIVE,
  parameter int BUSOFF_LVL  = DEF_BUSOFF,
  parameter int TX_INC      = DEF_TX_INC,
  parameter int REC_RELOAD  = DEF_REC_RELOAD
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc_tx8,
  input  logic       i_dec_tx,
  input  logic       i_inc_rx1,
  input  logic       i_inc_rx8,
  input  logic       i_dec_rx,
  input  logic       i_rcv11,
  input  logic       i_busoff_clr,
  output logic [7:0] o_tec_count,
  output logic [7:0] o_rec_count,
  output logic       o_warning,
  output logic [1:0] o_fc_state,
  output logic       o_busoff
);
  fc_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] w_tec, w_tec_nxt, w_rec, w_rec_nxt;
  logic             w_hold, w_exit;
  assign w_hold = (r_state == FC_BUSOFF);
  can_err_counter #(
    .CNT_W(CNT_W), .STEP(TX_INC), .INC_LIM(BUSOFF_LVL),
    .RELOAD_EN(1'b0), .RELOAD_LVL(PASSIVE_LVL), .RELOAD_VAL(REC_RELOAD)
  ) u_tec (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc_step(i_inc_tx8), .i_inc_one(1'b0),
    .i_dec(i_dec_tx), .i_hold(w_hold), .i_clr(w_exit), .o_cnt(w_tec), .o_cnt_nxt(w_tec_nxt)
  );
  can_err_counter #(
    .CNT_W(CNT_W), .STEP(RX_INC8), .INC_LIM(1 << CNT_W),
    .RELOAD_EN(1'b1), .RELOAD_LVL(PASSIVE_LVL), .RELOAD_VAL(REC_RELOAD)
  ) u_rec (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc_step(i_inc_rx8), .i_inc_one(i_inc_rx1),
    .i_dec(i_dec_rx), .i_hold(w_hold), .i_clr(w_exit), .o_cnt(w_rec), .o_cnt_nxt(w_rec_nxt)
  );
`ifdef CAN_FC_BUSOFF_RECOVERY_EN
  logic       r_rcv_flag, w_rcv_edge, w_unused;
  logic [6:0] r_rcv_cnt;
  assign w_unused   = i_busoff_clr;
  assign w_rcv_edge = i_rcv11 & ~r_rcv_flag & w_hold;
  assign w_exit     = w_rcv_edge & (int'(r_rcv_cnt) == RCV11_EXIT_CNT - 1);
  // held at zero outside bus-off, so it starts fresh on every entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rcv_flag <= 1'b0;
      r_rcv_cnt  <= '0;
    end else begin
      r_rcv_flag <= i_rcv11;
      r_rcv_cnt  <= (!w_hold || w_exit) ? '0 : r_rcv_cnt + 7'(w_rcv_edge);
    end
  end
`else
  logic w_unused;
  assign w_unused = i_rcv11;
  assign w_exit   = w_hold & i_busoff_clr;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FC_ACTIVE;
    else          r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = w_hold ? (w_exit ? FC_ACTIVE : FC_BUSOFF) :
                  (int'(w_tec_nxt) >= BUSOFF_LVL) ? FC_BUSOFF :
                  (int'(w_tec_nxt) >= PASSIVE_LVL || int'(w_rec_nxt) >= PASSIVE_LVL) ? FC_PASSIVE :
                  FC_ACTIVE;
  end
  always_comb begin
    o_tec_count = sat8(32'(w_tec));
    o_rec_count = sat8(32'(w_rec));
    o_warning   = int'(w_tec) >= WARN_LVL || int'(w_rec) >= WARN_LVL;
    o_fc_state  = r_state;
    o_busoff    = w_hold;
  end
endmodule
